imem_access_arbiter: RTL

- Arbitrates the single-port instruction memory between two requesters: a program loader (writes) and the CPU fetch stage (reads).
- Sequences a boot phase. After reset, only the loader may write, until it flags the last word. Fetch is then enabled.
- In the run phase, the loader may still patch words at runtime. A starvation counter guarantees fetch forward progress.
- Sits between the loader/fetch stage and the instruction memory array; the memory has 1-cycle synchronous read latency.

---
 rtl/imem_access_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/imem_access_arbiter.sv
// Single-port instruction memory arbiter: boot-phase loader, then run-phase
// loader/fetch sharing with a starvation guard for fetch.
module imem_access_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned INSTR_W  = 19,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [ADDR_W-1:0]  f_addr,
  output logic               f_rsp_valid,
  output logic [INSTR_W-1:0] f_rsp_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               boot_done
);

  localparam int unsigned WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic {BOOT, RUN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_nxt;
  logic           r_rsp_valid;
  logic           w_ld_acc;
  logic           w_f_acc;

  // State register plus the wait counter and response flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= BOOT;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_rsp_valid <= w_f_acc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == BOOT && w_ld_acc && ld_last) begin
      w_state_nxt = RUN;
    end
  end

  // Grant rule: a starved fetch preempts the loader; otherwise the loader wins.
  always_comb begin
    ld_ready = 1'b1;
    f_ready  = 1'b0;
    if (r_state == RUN) begin
      if (f_valid && r_wait_cnt == WAIT_MAX) begin
        ld_ready = 1'b0;
        f_ready  = 1'b1;
      end else if (ld_valid) begin
        ld_ready = 1'b1;
        f_ready  = 1'b0;
      end else begin
        ld_ready = 1'b1;
        f_ready  = 1'b1;
      end
    end
  end

  assign w_ld_acc = ld_valid && ld_ready;
  assign w_f_acc  = f_valid && f_ready;

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (r_state == BOOT || !f_valid || w_f_acc) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      w_wait_nxt = r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ld_acc) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (w_f_acc) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
    end
  end

  assign f_rsp_valid = r_rsp_valid;
  assign f_rsp_data  = r_rsp_valid ? mem_rdata : '0;
  assign boot_done   = (r_state == RUN);

endmodule
